sens_hispi12l4_tx: RTL



---
 rtl/sens_hispi12l4_tx_if.sv | 25 ++
 rtl/sens_hispi12l4_tx.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sens_hispi12l4_tx_if.sv
// Frame-control and lane-word bundle for the 4-lane 12-bit packetized-SP HiSPi transmitter.
// The master modport is the frame source; the slave modport is the transmitter.
interface sens_hispi12l4_tx_if;
    logic        frame_start;
    logic [13:0] line_quads;
    logic [15:0] frame_lines;
    logic [7:0]  hblank;
    logic [47:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [47:0] lane_d;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    modport master (
        output frame_start, line_quads, frame_lines, hblank, din, din_valid,
        input  din_ready, lane_d, busy, frame_done, underrun
    );

    modport slave (
        input  frame_start, line_quads, frame_lines, hblank, din, din_valid,
        output din_ready, lane_d, busy, frame_done, underrun
    );
endinterface

// File: rtl/sens_hispi12l4_tx.sv
// Packetized-SP HiSPi transmitter, 4 lanes x 12 bits, with SOF/SOL/EOL/EOF sync and blanking filler.
// Optional HISPI_TX_CLIP_EN: data words equal to 12'hFFF are sent as 12'hFFE so pixels never mimic a sync header.
module sens_hispi12l4_tx #(
    parameter int          HISPI_NUMLANES = 4,
    parameter logic [11:0] HISPI_IDLE     = 12'h001
) (
    input logic                 pclk,
    input logic                 prst_n,
    sens_hispi12l4_tx_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, SYNC_S, DATA, SYNC_E, HBL} state_t;

    state_t      r_state, w_stateNext;
    logic [1:0]  r_phase;
    logic [13:0] r_quad, r_quadLast;
    logic [15:0] r_line, r_lineLast;
    logic [7:0]  r_hbl, r_hblLen;
    logic [47:0] r_laneD, w_laneNext, w_dinClip;
    logic        r_busy, r_done, r_underrun;
    logic        w_busyNext, w_doneNext, w_lastLine, w_accept;

    function automatic logic [11:0] fnClip(input logic [11:0] w);
`ifdef HISPI_TX_CLIP_EN
        return (w == 12'hFFF) ? 12'hFFE : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [11:0] fnSync(input logic [1:0] ph, input logic [11:0] code);
        case (ph)
            2'd0:    return 12'hFFF;
            2'd3:    return code;
            default: return 12'h000;
        endcase
    endfunction

    always_comb begin
        w_dinClip = bus.din;
        for (int i = 0; i < HISPI_NUMLANES; i++) begin
            w_dinClip[12*i +: 12] = fnClip(bus.din[12*i +: 12]);
        end
    end

    assign w_lastLine = (r_line == r_lineLast);
    assign w_accept   = (r_state == IDLE) && bus.frame_start;

    // Next state and the lane word to register this cycle; lane_d lags the state by one edge.
    always_comb begin
        w_stateNext = r_state;
        w_laneNext  = {HISPI_NUMLANES{HISPI_IDLE}};
        case (r_state)
            IDLE: begin
                if (bus.frame_start) w_stateNext = SYNC_S;
            end
            SYNC_S: begin
                w_laneNext = {HISPI_NUMLANES{fnSync(r_phase, (r_line == 16'd0) ? 12'h003 : 12'h001)}};
                if (r_phase == 2'd3) w_stateNext = DATA;
            end
            DATA: begin
                w_laneNext = bus.din_valid ? w_dinClip : r_laneD;
                if (r_quad == r_quadLast) w_stateNext = SYNC_E;
            end
            SYNC_E: begin
                w_laneNext = {HISPI_NUMLANES{fnSync(r_phase, w_lastLine ? 12'h007 : 12'h005)}};
                if (r_phase == 2'd3) begin
                    if (w_lastLine)              w_stateNext = IDLE;
                    else if (r_hblLen == 8'd0)   w_stateNext = SYNC_S;
                    else                         w_stateNext = HBL;
                end
            end
            HBL: begin
                if (r_hbl == r_hblLen - 8'd1) w_stateNext = SYNC_S;
            end
            default: w_stateNext = IDLE;
        endcase
        w_busyNext = (r_state != IDLE) && (w_stateNext != IDLE);
        w_doneNext = (r_state == SYNC_E) && (r_phase == 2'd3) && w_lastLine;
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Counters, latched frame geometry and registered outputs.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_phase    <= 2'd0;
            r_quad     <= 14'd0;
            r_quadLast <= 14'd0;
            r_line     <= 16'd0;
            r_lineLast <= 16'd0;
            r_hbl      <= 8'd0;
            r_hblLen   <= 8'd0;
            r_laneD    <= {HISPI_NUMLANES{HISPI_IDLE}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_laneD <= w_laneNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
            r_phase <= (r_state == SYNC_S || r_state == SYNC_E) ? r_phase + 2'd1 : 2'd0;
            r_quad  <= (r_state == DATA && w_stateNext == DATA) ? r_quad + 14'd1 : 14'd0;
            r_hbl   <= (r_state == HBL && w_stateNext == HBL) ? r_hbl + 8'd1 : 8'd0;
            if (w_accept) begin
                r_quadLast <= (bus.line_quads == 14'd0) ? 14'd0 : bus.line_quads - 14'd1;
                r_lineLast <= (bus.frame_lines == 16'd0) ? 16'd0 : bus.frame_lines - 16'd1;
                r_hblLen   <= bus.hblank;
                r_line     <= 16'd0;
                r_underrun <= 1'b0;
            end else begin
                if (r_state == SYNC_E && r_phase == 2'd3) r_line <= r_line + 16'd1;
                if (r_state == DATA && !bus.din_valid)   r_underrun <= 1'b1;
            end
        end
    end

    assign bus.din_ready  = (r_state == DATA);
    assign bus.lane_d     = r_laneD;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
    assign bus.underrun   = r_underrun;

endmodule
